// File: rtl/ct_mmu_jtlb_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ct_mmu_jtlb_tag_ctrl
// Description : JTLB tag-array port arbiter with invalidate-all sweep engine.
//               Optional lookup aging enabled by JTLB_TAG_LKUP_AGE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ct_mmu_jtlb_tag_ctrl #(
  parameter int INV_ENTRIES = 256,
  parameter int AGE_MAX     = 3
) (
  input  logic         forever_cpuclk,
  input  logic         cpurst,
  input  logic         lkup_req,
  input  logic [7:0]   lkup_idx,
  output logic         lkup_gnt,
  output logic         lkup_dout_vld,
  input  logic         rf_req,
  input  logic [7:0]   rf_idx,
  input  logic [4:0]   rf_wen,
  input  logic [195:0] rf_din,
  output logic         rf_gnt,
  input  logic         inv_all_req,
  output logic         inv_busy,
  output logic         inv_done,
  output logic         jtlb_tag_cen,
  output logic [7:0]   jtlb_tag_idx,
  output logic [4:0]   jtlb_tag_wen,
  output logic [195:0] jtlb_tag_din
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_sweep = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;
  localparam logic [7:0] c_last_idx = 8'(INV_ENTRIES - 1);

  // The sweep index and the age counter are fixed at 8 and 2 bits wide.
  if (INV_ENTRIES < 1 || INV_ENTRIES > 256) begin : g_bad_inv_entries
    $error("INV_ENTRIES must be in 1..256");
  end
  if (AGE_MAX < 1 || AGE_MAX > 3) begin : g_bad_age_max
    $error("AGE_MAX must be in 1..3");
  end

  logic [1:0] r_state;
  logic [7:0] r_sweep_idx;
  logic       r_lkup_dout_vld;
  logic       w_idle;
  logic       w_arb_ok;
  logic       w_age_win;
  logic       w_rf_gnt;
  logic       w_lkup_gnt;

  assign w_idle     = (r_state == c_st_idle);
  // A pending invalidate-all takes the port before any requester.
  assign w_arb_ok   = w_idle && !inv_all_req;
  assign w_rf_gnt   = w_arb_ok && rf_req && !w_age_win;
  assign w_lkup_gnt = w_arb_ok && lkup_req && !w_rf_gnt;

`ifdef JTLB_TAG_LKUP_AGE_EN
  localparam logic [1:0] c_age_max = 2'(AGE_MAX);
  logic [1:0] r_age;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_age <= 2'd0;
    end else if (w_idle) begin
      if (lkup_req && !w_lkup_gnt) begin
        r_age <= (r_age == c_age_max) ? r_age : r_age + 2'd1;
      end else begin
        r_age <= 2'd0;
      end
    end
  end

  assign w_age_win = lkup_req && (r_age == c_age_max);
`else
  assign w_age_win = 1'b0;
`endif

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_state         <= c_st_idle;
      r_sweep_idx     <= 8'd0;
      r_lkup_dout_vld <= 1'b0;
    end else begin
      r_lkup_dout_vld <= w_lkup_gnt;
      case (r_state)
        c_st_idle: begin
          r_sweep_idx <= 8'd0;
          if (inv_all_req) begin
            r_state <= c_st_sweep;
          end
        end
        c_st_sweep: begin
          if (r_sweep_idx == c_last_idx) begin
            r_state     <= c_st_done;
            r_sweep_idx <= 8'd0;
          end else begin
            r_sweep_idx <= r_sweep_idx + 8'd1;
          end
        end
        c_st_done: r_state <= c_st_idle;
        default:   r_state <= c_st_idle;
      endcase
    end
  end

  always_comb begin
    jtlb_tag_cen = 1'b0;
    jtlb_tag_idx = 8'd0;
    jtlb_tag_wen = 5'd0;
    jtlb_tag_din = '0;
    if (r_state == c_st_sweep) begin
      jtlb_tag_cen = 1'b1;
      jtlb_tag_idx = r_sweep_idx;
      jtlb_tag_wen = 5'b11111;
    end else if (w_rf_gnt) begin
      jtlb_tag_cen = 1'b1;
      jtlb_tag_idx = rf_idx;
      jtlb_tag_wen = rf_wen;
      jtlb_tag_din = rf_din;
    end else if (w_lkup_gnt) begin
      jtlb_tag_cen = 1'b1;
      jtlb_tag_idx = lkup_idx;
    end
  end

  assign rf_gnt        = w_rf_gnt;
  assign lkup_gnt      = w_lkup_gnt;
  assign lkup_dout_vld = r_lkup_dout_vld;
  assign inv_busy      = !w_idle;
  assign inv_done      = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_ct_mmu_jtlb_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ct_mmu_jtlb_tag_ctrl
// Description : Scoreboard bench for ct_mmu_jtlb_tag_ctrl (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_mmu_jtlb_tag_ctrl;

  localparam int N  = 256;
  localparam int AM = 3;
`ifdef JTLB_TAG_LKUP_AGE_EN
  localparam bit AGE_EN = 1'b1;
`else
  localparam bit AGE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         lkup_req;
  logic [7:0]   lkup_idx;
  logic         lkup_gnt;
  logic         lkup_dout_vld;
  logic         rf_req;
  logic [7:0]   rf_idx;
  logic [4:0]   rf_wen;
  logic [195:0] rf_din;
  logic         rf_gnt;
  logic         inv_all_req;
  logic         inv_busy;
  logic         inv_done;
  logic         cen;
  logic [7:0]   idx;
  logic [4:0]   wen;
  logic [195:0] din;

  ct_mmu_jtlb_tag_ctrl #(.INV_ENTRIES(N), .AGE_MAX(AM)) dut (
    .forever_cpuclk(clk),
    .cpurst(rst),
    .lkup_req(lkup_req),
    .lkup_idx(lkup_idx),
    .lkup_gnt(lkup_gnt),
    .lkup_dout_vld(lkup_dout_vld),
    .rf_req(rf_req),
    .rf_idx(rf_idx),
    .rf_wen(rf_wen),
    .rf_din(rf_din),
    .rf_gnt(rf_gnt),
    .inv_all_req(inv_all_req),
    .inv_busy(inv_busy),
    .inv_done(inv_done),
    .jtlb_tag_cen(cen),
    .jtlb_tag_idx(idx),
    .jtlb_tag_wen(wen),
    .jtlb_tag_din(din)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         lg;
    logic         rg;
    logic         cen;
    logic [7:0]   idx;
    logic [4:0]   wen;
    logic [195:0] din;
    logic         vld;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   n_sweep_acc = 0;

  // Reference model: position within an invalidate sweep (-1 = idle), the
  // pending read-valid, and the consecutive-denial count of the lookup port.
  int sweep_pos = -1;
  bit m_vld     = 1'b0;
  int m_age     = 0;

  function automatic logic [195:0] rnd196();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[32*i +: 32] = $urandom;
    return t[195:0];
  endfunction

  task automatic step(input bit r, input bit lk, input logic [7:0] li,
                      input bit rf, input logic [7:0] ri, input logic [4:0] rw,
                      input logic [195:0] rd, input bit inv);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    lkup_req    = lk & ~r;
    lkup_idx    = li;
    rf_req      = rf & ~r;
    rf_idx      = ri;
    rf_wen      = rw;
    rf_din      = rd;
    inv_all_req = inv & ~r;
    e = '0;
    if (r) begin
      sweep_pos = -1;
      m_vld     = 1'b0;
      m_age     = 0;
    end else begin
      e.vld = m_vld;
      if (sweep_pos >= 0 && sweep_pos < N) begin
        e.busy = 1'b1;
        e.cen  = 1'b1;
        e.idx  = 8'(sweep_pos);
        e.wen  = 5'b11111;
        sweep_pos++;
      end else if (sweep_pos == N) begin
        e.busy    = 1'b1;
        e.done    = 1'b1;
        sweep_pos = -1;
      end else begin
        if (inv) begin
          sweep_pos = 0;
        end else if (rf && !(AGE_EN && lk && m_age == AM)) begin
          e.rg = 1'b1; e.cen = 1'b1; e.idx = ri; e.wen = rw; e.din = rd;
        end else if (lk) begin
          e.lg = 1'b1; e.cen = 1'b1; e.idx = li;
        end
        if (AGE_EN) m_age = (lk && !e.lg) ? ((m_age < AM) ? m_age + 1 : AM) : 0;
      end
      m_vld = e.lg;
    end
    q.push_back(e);
  endtask

  // Monitor: mid-cycle, compare DUT outputs with the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = q.pop_front();
      a = '{lg: lkup_gnt, rg: rf_gnt, cen: cen, idx: idx, wen: wen, din: din,
            vld: lkup_dout_vld, busy: inv_busy, done: inv_done};
      n_chk++;
      if (a.done && !rst) n_done++;
      if (a.cen && a.wen == 5'b11111 && a.busy) n_sweep_acc++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL port_cycle t=%0t got lg=%b rg=%b cen=%b idx=%h wen=%b vld=%b busy=%b done=%b din=%h want lg=%b rg=%b cen=%b idx=%h wen=%b vld=%b busy=%b done=%b din=%h",
                 $time, a.lg, a.rg, a.cen, a.idx, a.wen, a.vld, a.busy, a.done, a.din,
                 e.lg, e.rg, e.cen, e.idx, e.wen, e.vld, e.busy, e.done, e.din);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [195:0] d;
    int done_before;
    int acc_before;
    rst = 1'b1; lkup_req = 0; lkup_idx = 0; rf_req = 0; rf_idx = 0;
    rf_wen = 0; rf_din = '0; inv_all_req = 0;
    d = rnd196();

    repeat (3) step(1, 1, 8'h11, 1, 8'h22, 5'h1f, d, 0);
    step(0, 1, 8'h5A, 0, 8'h00, 5'h00, '0, 0);
    repeat (2) step(0, 0, 8'h00, 0, 8'h00, 5'h00, '0, 0);

    // Full sweep with both requesters holding and a re-trigger at idx 10.
    done_before = n_done;
    acc_before  = n_sweep_acc;
    for (int i = 0; i < 262; i++)
      step(0, 1, 8'h33, 1, 8'hC4, 5'b10101, d, (i == 0) || (i == 11));
    repeat (2) step(0, 0, 8'h00, 0, 8'h00, 5'h00, '0, 0);
    n_chk++;
    if (n_done - done_before != 1 || n_sweep_acc - acc_before != N) begin
      n_fail++;
      $display("FAIL sweep_len got done_pulses=%0d sweep_cycles=%0d want 1 and %0d",
               n_done - done_before, n_sweep_acc - acc_before, N);
    end

    // Both requesters held: aging decides whether lookup ever wins.
    for (int i = 0; i < 8; i++) step(0, 1, 8'h44, 1, 8'h55, 5'b00000, d, 0);

    // Reset in the middle of a sweep, then a fresh sweep from index 0.
    done_before = n_done;
    for (int i = 0; i < 101; i++) step(0, 0, 8'h00, 0, 8'h00, 5'h00, '0, i == 0);
    step(1, 0, 8'h00, 0, 8'h00, 5'h00, '0, 0);
    repeat (3) step(0, 0, 8'h00, 0, 8'h00, 5'h00, '0, 0);
    n_chk++;
    if (n_done != done_before) begin
      n_fail++;
      $display("FAIL reset_abort got done_pulses=%0d want 0", n_done - done_before);
    end
    for (int i = 0; i < 260; i++) step(0, 0, 8'h00, 0, 8'h00, 5'h00, '0, i == 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [4:0] w;
      w = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      step($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
           $urandom_range(0, 2) == 0, 8'($urandom), w, rnd196(),
           $urandom_range(0, 299) == 0);
    end

    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ct_mmu_jtlb_tag_ctrl.md
CT_MMU_JTLB_TAG_CTRL -- requirements
Module: ct_mmu_jtlb_tag_ctrl

Interface
REQ-001 Parameter INV_ENTRIES, default 256: number of tag-array indices walked by invalidate-all.
REQ-002 Parameter AGE_MAX, default 3: lookup-denial count that forces a lookup grant (used only when JTLB_TAG_LKUP_AGE_EN is defined).
REQ-003 forever_cpuclk  in  1  sole clock; rising edge.
REQ-004 cpurst  in  1  reset, asynchronous, active-high.
REQ-005 lkup_req  in  1  lookup read request.
REQ-006 lkup_idx  in  8  lookup index.
REQ-007 lkup_gnt  out  1  lookup granted this cycle.
REQ-008 lkup_dout_vld  out  1  tag-array read data valid (cycle after lkup_gnt).
REQ-009 rf_req  in  1  refill write request.
REQ-010 rf_idx  in  8  refill index.
REQ-011 rf_wen  in  5  refill way/fifo write enables ([4] fifo, [3:0] way3..way0).
REQ-012 rf_din  in  196  refill write data.
REQ-013 rf_gnt  out  1  refill granted this cycle.
REQ-014 inv_all_req  in  1  single-cycle pulse starting invalidate-all.
REQ-015 inv_busy  out  1  invalidate-all sweep in progress.
REQ-016 inv_done  out  1  single-cycle pulse when sweep completes.
REQ-017 jtlb_tag_cen  out  1  array access enable (active-high).
REQ-018 jtlb_tag_idx  out  8  array index.
REQ-019 jtlb_tag_wen  out  5  array write enables; 0 = read.
REQ-020 jtlb_tag_din  out  196  array write data.

Function
REQ-021 FSM states: IDLE, SWEEP, DONE; IDLE->SWEEP on inv_all_req; SWEEP->DONE on cycle with sweep index = INV_ENTRIES-1; DONE->IDLE unconditionally after one cycle.
REQ-022 In SWEEP: cen=1, idx=sweep counter, wen=5'b11111, din=0; counter starts at 0, increments by 1 per cycle, sweep lasts exactly INV_ENTRIES cycles.
REQ-023 inv_busy=1 in SWEEP and DONE; inv_done=1 only in DONE.
REQ-024 In SWEEP and DONE, lkup_gnt=0 and rf_gnt=0; requests are held by requesters, not dropped.
REQ-025 inv_all_req while inv_busy=1 is ignored (no restart, no queued second sweep).
REQ-026 inv_all_req in the same cycle as lkup_req/rf_req in IDLE: sweep wins, no grant that cycle, SWEEP entered next cycle.
REQ-027 In IDLE without inv_all_req: rf_req granted over lkup_req (subject to REQ-034); grants are combinational in the requesting cycle.
REQ-028 Refill grant: cen=1, idx=rf_idx, wen=rf_wen, din=rf_din; rf_req with rf_wen=0 is granted and produces a read-shaped access (no write).
REQ-029 Lookup grant: cen=1, idx=lkup_idx, wen=0, din=0.
REQ-030 No grant: cen=0, idx=0, wen=0, din=0.
REQ-031 lkup_dout_vld is a register set exactly one cycle after lkup_gnt=1, else 0; fixed read latency 1.
REQ-032 At most one of lkup_gnt, rf_gnt, sweep access per cycle.

Reset
REQ-033 cpurst=1 forces asynchronously: state IDLE, sweep counter 0, age counter 0, lkup_dout_vld 0, inv_busy 0, inv_done 0; reset mid-sweep abandons sweep with no inv_done.

Configuration
REQ-034 JTLB_TAG_LKUP_AGE_EN defined: 2-bit age counter increments on each IDLE cycle with lkup_req=1 and lkup_gnt=0 (saturating at AGE_MAX), clears on lkup_gnt or lkup_req=0; when counter = AGE_MAX, lookup wins over refill. Undefined: strict refill-over-lookup priority, no counter.

Verification
REQ-035 inv_all_req pulse in IDLE -> 256 cycles cen=1, wen=11111, din=0, idx 0..255; inv_done one cycle after idx=255; inv_busy 257 cycles.
REQ-036 rf_req+lkup_req held during sweep -> no grants until IDLE; first IDLE cycle rf_gnt=1, idx=rf_idx.
REQ-037 lkup_req alone, lkup_idx=8'h5A -> lkup_gnt same cycle, idx=5A, wen=0; lkup_dout_vld=1 next cycle only.
REQ-038 AGE_EN: rf_req and lkup_req both held continuously -> rf_gnt cycles 1-3, lkup_gnt cycle 4; without macro lkup_gnt never asserted.
REQ-039 cpurst asserted at sweep idx=100 -> outputs immediately idle, inv_done never pulses; fresh inv_all_req restarts at idx 0.
REQ-040 Second inv_all_req at sweep idx=10 -> ignored; total sweep still 256 cycles, single inv_done.
